cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_control_pkg.sv | 16 +
 rtl/cache_control_if.sv | 38 +++
 rtl/cache_control_perf_counters.sv | 42 ++++
 rtl/cache_control.sv | 139 +++++++++++++
 tb/tb_cache_control.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cache_control_pkg.sv
// Shared types for the two-way cache controller: FSM states, way index and a way-to-mask helper.
package cache_ctrl_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    typedef logic way_t;

    function automatic logic [1:0] way_mask(way_t w);
        return w ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_control_if.sv
// CPU, physical-memory and datapath signals of the cache controller.
// slave = controller side, master = CPU/datapath side.
interface cache_control_if;

    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_resp;
    logic [1:0] hit;
    logic [1:0] valid;
    logic [1:0] dirty;
    logic       lru;
    logic [1:0] load_data;
    logic [1:0] load_tag;
    logic [1:0] set_valid;
    logic [1:0] set_dirty;
    logic [1:0] clr_dirty;
    logic       load_lru;
    logic       lru_in;
    logic       data_sel;
    logic       pmem_addr_sel;
    logic       way_sel;

    modport slave (
        input  mem_read, mem_write, pmem_resp, hit, valid, dirty, lru,
        output mem_resp, pmem_read, pmem_write, load_data, load_tag, set_valid,
               set_dirty, clr_dirty, load_lru, lru_in, data_sel, pmem_addr_sel, way_sel
    );

    modport master (
        output mem_read, mem_write, pmem_resp, hit, valid, dirty, lru,
        input  mem_resp, pmem_read, pmem_write, load_data, load_tag, set_valid,
               set_dirty, clr_dirty, load_lru, lru_in, data_sel, pmem_addr_sel, way_sel
    );

endinterface

// File: rtl/cache_control_perf_counters.sv
// Saturating hit/miss/writeback counters; only instantiated when CACHE_PERF_CNT_EN is defined.
module cache_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resp,
    input  logic             miss,
    input  logic             wb_exit,
    input  logic             idle_no_req,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    // Set while a request is being serviced by a miss, so its final IDLE hit is not a first-cycle hit.
    logic retry;
    logic hit_inc;

    assign hit_inc = resp && !retry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry      <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (miss)
                retry <= 1'b1;
            else if (resp || idle_no_req)
                retry <= 1'b0;
            if (hit_inc && (hit_count != '1))
                hit_count <= hit_count + 1'b1;
            if (miss && (miss_count != '1))
                miss_count <= miss_count + 1'b1;
            if (wb_exit && (wb_count != '1))
                wb_count <= wb_count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_control.sv
// Two-way write-back cache controller FSM. Optional perf counters under CACHE_PERF_CNT_EN.
//   state     | meaning
//   IDLE      | serve hits combinationally; on miss latch victim=lru
//   WRITEBACK | write dirty victim line to pmem
//   ALLOCATE  | fill victim way from pmem, then retry as hit in IDLE
module cache_control
    import cache_ctrl_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    cache_control_if.slave   bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t     state, state_d;
    way_t       victim, victim_d;
    way_t       hit_way;
    logic       req, is_write, hit_any;
    logic       resp_c, pr_c, pw_c, ll_c, li_c, ds_c, pas_c, ws_c;
    logic [1:0] ld_c, lt_c, sv_c, sd_c, cd_c;

    assign req      = bus.mem_read || bus.mem_write;
    assign is_write = bus.mem_write;
    assign hit_any  = |bus.hit;
    assign hit_way  = ~bus.hit[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            victim <= 1'b0;
        end else begin
            state  <= state_d;
            victim <= victim_d;
        end
    end

    always_comb begin
        state_d  = state;
        victim_d = victim;
        resp_c   = 1'b0;
        pr_c     = 1'b0;
        pw_c     = 1'b0;
        ll_c     = 1'b0;
        li_c     = 1'b0;
        ds_c     = 1'b0;
        pas_c    = 1'b0;
        ws_c     = 1'b0;
        ld_c     = '0;
        lt_c     = '0;
        sv_c     = '0;
        sd_c     = '0;
        cd_c     = '0;
        case (state)
            IDLE: begin
                if (req && hit_any) begin
                    resp_c = 1'b1;
                    ll_c   = 1'b1;
                    li_c   = ~hit_way;
                    ws_c   = hit_way;
                    if (is_write) begin
                        ld_c = way_mask(hit_way);
                        sd_c = way_mask(hit_way);
                    end
                end else if (req) begin
                    victim_d = bus.lru;
                    state_d  = (bus.valid[bus.lru] && bus.dirty[bus.lru]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pw_c  = 1'b1;
                pas_c = 1'b1;
                ws_c  = victim;
                if (bus.pmem_resp)
                    state_d = ALLOCATE;
            end
            ALLOCATE: begin
                pr_c = 1'b1;
                if (bus.pmem_resp) begin
                    ld_c    = way_mask(victim);
                    lt_c    = way_mask(victim);
                    sv_c    = way_mask(victim);
                    cd_c    = way_mask(victim);
                    ds_c    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // IDLE hits are combinational on CPU inputs, so outputs are masked directly by reset.
    assign bus.mem_resp      = rst & resp_c;
    assign bus.pmem_read     = rst & pr_c;
    assign bus.pmem_write    = rst & pw_c;
    assign bus.load_lru      = rst & ll_c;
    assign bus.lru_in        = rst & li_c;
    assign bus.data_sel      = rst & ds_c;
    assign bus.pmem_addr_sel = rst & pas_c;
    assign bus.way_sel       = rst & ws_c;
    assign bus.load_data     = {2{rst}} & ld_c;
    assign bus.load_tag      = {2{rst}} & lt_c;
    assign bus.set_valid     = {2{rst}} & sv_c;
    assign bus.set_dirty     = {2{rst}} & sd_c;
    assign bus.clr_dirty     = {2{rst}} & cd_c;

`ifdef CACHE_PERF_CNT_EN
    logic miss_evt, wb_exit, idle_no_req;

    assign miss_evt    = (state == IDLE) && req && !hit_any;
    assign wb_exit     = (state == WRITEBACK) && bus.pmem_resp;
    assign idle_no_req = (state == IDLE) && !req;

    cache_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .resp        (bus.mem_resp),
        .miss        (miss_evt),
        .wb_exit     (wb_exit),
        .idle_no_req (idle_no_req),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .wb_count    (wb_count)
    );
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: hits, clean/dirty misses, dropped requests, reset, saturation.
module tb_cache_control;

    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cache_control_if bus ();

`ifdef CACHE_PERF_CNT_EN
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;
`endif

    cache_control #(
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rd, input logic wr, input logic [1:0] h, input logic [1:0] v,
                         input logic [1:0] d, input logic l, input logic presp);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.hit       = h;
        bus.valid     = v;
        bus.dirty     = d;
        bus.lru       = l;
        bus.pmem_resp = presp;
    endtask

    task automatic expect_out(input string tag, input logic resp, input logic pr, input logic pw,
                              input logic [1:0] ld, input logic [1:0] lt, input logic [1:0] sv,
                              input logic [1:0] sd, input logic [1:0] cd, input logic ll,
                              input logic li, input logic ds, input logic pas, input logic ws);
        logic [17:0] exp_v, obs_v;
        exp_v = {resp, pr, pw, ld, lt, sv, sd, cd, ll, li, ds, pas, ws};
        obs_v = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.load_data, bus.load_tag,
                 bus.set_valid, bus.set_dirty, bus.clr_dirty, bus.load_lru, bus.lru_in,
                 bus.data_sel, bus.pmem_addr_sel, bus.way_sel};
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs_v, exp_v);
        end
    endtask

    task automatic expect_zero(input string tag);
        expect_out(tag, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_counts(input string tag, input int h, input int m, input int w);
`ifdef CACHE_PERF_CNT_EN
        logic [3*CNT_W-1:0] exp_c, obs_c;
        exp_c = {h[CNT_W-1:0], m[CNT_W-1:0], w[CNT_W-1:0]};
        obs_c = {hit_count, miss_count, wb_count};
        checks++;
        assert (obs_c === exp_c) else begin
            failures++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs_c, exp_c);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive(1, 0, 2'b01, 2'b11, 2'b00, 0, 1);
        #1 expect_zero("reset_outputs_zero");
        expect_counts("reset_counts", 0, 0, 0);

        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 2'b10, 2'b11, 2'b00, 1, 0);
        #1 expect_out("read_hit_way1", 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1);

        @(negedge clk);
        drive(0, 1, 2'b01, 2'b11, 2'b00, 1, 0);
        #1 expect_out("write_hit_way0", 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1, 1, 0, 0, 0);

        @(negedge clk);
        drive(0, 1, 2'b11, 2'b11, 2'b00, 1, 0);
        #1 expect_out("both_hit_way0_prio", 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1, 1, 0, 0, 0);

        @(negedge clk);
        drive(1, 1, 2'b10, 2'b11, 2'b00, 0, 0);
        #1 expect_out("read_write_is_write", 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1, 0, 0, 0, 1);

        @(negedge clk);
        drive(0, 0, 2'b11, 2'b11, 2'b00, 0, 1);
        #1 expect_zero("idle_ignores_pmem_resp");
        @(negedge clk);
        #1 expect_zero("idle_stays_idle");

        // clean miss, victim way 1; lru changes later to show the victim was latched
        @(negedge clk);
        drive(1, 0, 2'b00, 2'b01, 2'b00, 1, 0);
        #1 expect_zero("clean_miss_no_resp");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
            #1 expect_out("alloc_wait", 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1 expect_out("alloc_fill_way1", 0, 1, 0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(1, 0, 2'b10, 2'b11, 2'b00, 0, 0);
        #1 expect_out("clean_miss_then_hit", 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 2'b00, 2'b11, 2'b00, 0, 0);
        #1 expect_zero("idle_after_clean_miss");
        expect_counts("counts_after_clean_miss", 4, 1, 0);

        // dirty miss, victim way 0
        @(negedge clk);
        drive(0, 1, 2'b00, 2'b01, 2'b01, 0, 0);
        #1 expect_zero("dirty_miss_no_resp");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 expect_out("wb_wait_way0", 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        end
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1 expect_out("wb_done_way0", 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        #1 expect_out("wb_then_alloc", 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1 expect_out("alloc_fill_way0", 0, 1, 0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(0, 1, 2'b01, 2'b01, 2'b00, 0, 0);
        #1 expect_out("dirty_miss_then_hit", 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 2'b00, 2'b11, 2'b00, 0, 0);
        #1 expect_counts("counts_after_dirty_miss", 4, 2, 1);

        // dirty miss on way 1 whose request drops during writeback, then reset mid-allocate
        @(negedge clk);
        drive(1, 0, 2'b00, 2'b11, 2'b10, 1, 0);
        #1 expect_zero("dirty_miss_way1");
        @(negedge clk);
        drive(0, 0, 2'b00, 2'b11, 2'b10, 1, 0);
        #1 expect_out("wb_way1_req_dropped", 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 1);
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1 expect_out("wb_way1_done", 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 1);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        #1 expect_out("alloc_after_drop", 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        expect_counts("counts_before_reset", 4, 3, 2);
        #2 rst = 1'b0;
        #1 expect_zero("reset_mid_alloc");
        expect_counts("counts_cleared", 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 2'b00, 2'b11, 2'b00, 0, 1);
        #1 expect_zero("idle_after_reset");

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1, 0, 2'b10, 2'b11, 2'b00, 1, 0);
            #1 expect_out("sat_read_hit", 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1);
        end
        @(negedge clk);
        drive(0, 0, 2'b00, 2'b11, 2'b00, 0, 0);
        #1 expect_counts("hit_count_saturates", 15, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
